// File: rtl/montgomery_mul_serial.sv
// Bit-serial radix-2 Montgomery multiplier: result = A*B*2^-WIDTH mod M.
// Consumes one bit of A per clock, then does a single conditional subtraction.
module montgomery_mul_serial #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [WIDTH-1:0] m_in,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done,
    output logic             err
);

    localparam int unsigned CW = $clog2(WIDTH);

    typedef logic [WIDTH:0]   acc_t;
    typedef logic [WIDTH+1:0] sum_t;

    typedef enum logic [2:0] {
        StIdle,
        StPrecomp,
        StLoop,
        StCorrect,
        StFinish
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q, m_q, result_q;
    acc_t             mb_q, r_q;
    logic [CW-1:0]    cnt_q;
    logic             err_q;

    logic accept, last_bit, ai, q;
    sum_t addend;
    acc_t r_next, r_corr;

    always_comb begin
        accept   = (state_q == StIdle) && start && m_in[0];
        last_bit = (cnt_q == CW'(WIDTH - 1));
        ai       = a_q[0];
        q        = r_q[0] ^ (ai & b_q[0]);

        // Select rule: {ai,q} picks 0, M, B or M+B.
        unique case ({ai, q})
            2'b11:   addend = {1'b0, mb_q};
            2'b10:   addend = {2'b00, b_q};
            2'b01:   addend = {2'b00, m_q};
            default: addend = '0;
        endcase

        // Sum is even by choice of q, so the shift drops only a zero bit.
        r_next = acc_t'((sum_t'(r_q) + addend) >> 1);
        r_corr = (r_q >= acc_t'(m_q)) ? (r_q - acc_t'(m_q)) : r_q;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (accept) state_d = StPrecomp;
            StPrecomp: state_d = StLoop;
            StLoop:    if (last_bit) state_d = StCorrect;
            StCorrect: state_d = StFinish;
            StFinish:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            mb_q     <= '0;
            r_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= (state_q == StIdle) && start && !m_in[0];
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        a_q <= a_in;
                        b_q <= b_in;
                        m_q <= m_in;
                    end
                end
                StPrecomp: begin
                    mb_q  <= acc_t'(m_q) + acc_t'(b_q);
                    r_q   <= '0;
                    cnt_q <= '0;
                end
                StLoop: begin
                    r_q   <= r_next;
                    a_q   <= a_q >> 1;
                    cnt_q <= cnt_q + 1'b1;
                end
                StCorrect: begin
                    r_q      <= r_corr;
                    result_q <= r_corr[WIDTH-1:0];
                end
                default: ;
            endcase
        end
    end

    assign result = result_q;
    assign busy   = (state_q == StPrecomp) || (state_q == StLoop) || (state_q == StCorrect);
    assign done   = (state_q == StFinish);
    assign err    = err_q;

endmodule

// File: tb/tb_montgomery_mul_serial.sv
// Self-checking bench for montgomery_mul_serial at WIDTH=8 and WIDTH=16, directed plus
// random operands compared against a plain modular-arithmetic reference.
module tb_montgomery_mul_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start8 = 1'b0, start16 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0, m8 = '0;
    logic [15:0] a16 = '0, b16 = '0, m16 = '0;
    logic [7:0]  res8;
    logic [15:0] res16;
    logic        busy8, done8, err8, busy16, done16, err16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    montgomery_mul_serial #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a_in(a8), .b_in(b8), .m_in(m8),
        .result(res8), .busy(busy8), .done(done8), .err(err8)
    );

    montgomery_mul_serial #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(start16), .a_in(a16), .b_in(b16), .m_in(m16),
        .result(res16), .busy(busy16), .done(done16), .err(err16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // A*B*2^-w mod m: reduce the product, then halve w times modulo the odd m.
    function automatic longint model(input int w, input longint a, input longint b,
                                     input longint m);
        longint r = (a * b) % m;
        for (int i = 0; i < w; i++) r = (r % 2 == 0) ? r / 2 : (r + m) / 2;
        return r;
    endfunction

    task automatic drive(input int w, input logic s, input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] m);
        if (w == 8) begin
            start8 = s; a8 = a[7:0]; b8 = b[7:0]; m8 = m[7:0];
        end else begin
            start16 = s; a16 = a; b16 = b; m16 = m;
        end
    endtask

    function automatic logic [15:0] res_of(input int w);
        return (w == 8) ? {8'h00, res8} : res16;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 8) ? busy8 : busy16;
    endfunction
    function automatic logic done_of(input int w);
        return (w == 8) ? done8 : done16;
    endfunction
    function automatic logic err_of(input int w);
        return (w == 8) ? err8 : err16;
    endfunction

    // Called #1 after an edge; raises start, waits for the accept, checks latency and result.
    // poke: assert start with different operands mid-operation, which must be ignored.
    task automatic run(input string tag, input int w, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] m, input logic [15:0] exp, input bit poke);
        int  k;
        int  busy_gaps;
        bit  seen;
        seen = 0;
        drive(w, 1'b1, a, b, m);
        for (int t = 0; t < 3 && !seen; t++) begin
            @(posedge clk); #1;
            if (busy_of(w)) seen = 1;
        end
        chk({tag, "_accept"}, 64'(seen), 64'd1);
        drive(w, 1'b0, a, b, m);
        k = 1;
        busy_gaps = 0;
        while (!done_of(w) && k < w + 12) begin
            if (!busy_of(w)) busy_gaps++;
            if (poke && k == 3) drive(w, 1'b1, ~a, ~b, m ^ 16'h0002);
            else drive(w, 1'b0, ~a, ~b, m ^ 16'h0002);
            @(posedge clk); #1;
            k++;
        end
        drive(w, 1'b0, a, b, m);
        chk({tag, "_latency"}, 64'(k), 64'(w + 3));
        chk({tag, "_result"}, 64'(res_of(w)), 64'(exp));
        chk({tag, "_busy_gap"}, 64'(busy_gaps), 64'd0);
        chk({tag, "_busy_at_done"}, 64'(busy_of(w)), 64'd0);
        chk({tag, "_err_at_done"}, 64'(err_of(w)), 64'd0);
    endtask

    initial begin
        int done_seen;
        logic [15:0] ra, rb, rm;

        // Reset
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_result8", 64'(res8), 64'd0);
        chk("rst_busy8", 64'(busy8), 64'd0);
        chk("rst_done8", 64'(done8), 64'd0);
        chk("rst_err8", 64'(err8), 64'd0);
        chk("rst_result16", 64'(res16), 64'd0);
        chk("rst_busy16", 64'(busy16), 64'd0);
        @(posedge clk); #1;

        // T1-T3 directed, T2 pair back-to-back
        run("t1", 8, 16'd5, 16'd7, 16'd239, 16'd227, 1'b0);
        run("t2a", 8, 16'd1, 16'd1, 16'd239, 16'd225, 1'b0);
        run("t2b", 8, 16'd0, 16'd200, 16'd239, 16'd0, 1'b0);
        run("t3", 8, 16'd254, 16'd254, 16'd255, 16'd1, 1'b0);

        // T4: even modulus rejected
        repeat (2) @(posedge clk);
        #1;
        drive(8, 1'b1, 16'd5, 16'd7, 16'd238);
        @(posedge clk); #1;
        drive(8, 1'b0, 16'd5, 16'd7, 16'd238);
        chk("t4_err", 64'(err8), 64'd1);
        chk("t4_busy", 64'(busy8), 64'd0);
        chk("t4_done", 64'(done8), 64'd0);
        @(posedge clk); #1;
        chk("t4_err_pulse", 64'(err8), 64'd0);
        chk("t4_busy_after", 64'(busy8), 64'd0);
        chk("t4_result_kept", 64'(res8), 64'd1);

        // T5: reset mid-operation
        drive(8, 1'b1, 16'd5, 16'd7, 16'd239);
        @(posedge clk); #1;
        drive(8, 1'b0, 16'd5, 16'd7, 16'd239);
        chk("t5_busy_started", 64'(busy8), 64'd1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t5_rst_result", 64'(res8), 64'd0);
        chk("t5_rst_busy", 64'(busy8), 64'd0);
        chk("t5_rst_done", 64'(done8), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done8 || busy8) done_seen++;
        end
        chk("t5_no_done", 64'(done_seen), 64'd0);
        run("t5_rerun", 8, 16'd5, 16'd7, 16'd239, 16'd227, 1'b0);

        // T6: random back-to-back operations at both widths
        for (int i = 0; i < 1000; i++) begin
            rm = 16'($urandom_range(3, 255)) | 16'd1;
            ra = 16'($urandom % 32'(rm));
            rb = 16'($urandom % 32'(rm));
            if (i % 50 == 0) begin ra = rm - 16'd1; rb = rm - 16'd1; end
            run("t6_w8", 8, ra, rb, rm, 16'(model(8, ra, rb, rm)), (i % 7 == 0));
        end
        for (int i = 0; i < 1000; i++) begin
            rm = 16'($urandom_range(3, 65535)) | 16'd1;
            ra = 16'($urandom % 32'(rm));
            rb = 16'($urandom % 32'(rm));
            if (i % 50 == 0) begin ra = rm - 16'd1; rb = rm - 16'd1; end
            run("t6_w16", 16, ra, rb, rm, 16'(model(16, ra, rb, rm)), (i % 7 == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
